cluster_count_sequencer: RTL and testbench

- Controls and sequences the 768-strip cluster counter, which takes 768 valid-pattern flags and produces an 11-bit count 10 clock4x cycles later.
- Tracks each BX strobe through the counter pipeline and tags each counter output with its BX.
- Applies a programmable overflow threshold per BX.
- Runs slow-control-commanded occupancy windows (sum, max and overflow-BX count) with a valid/ack result handshake.

---
 rtl/cluster_count_pkg.sv | 18 +
 rtl/cluster_count_sequencer_delay.sv | 17 +
 rtl/cluster_count_sequencer.sv | 146 ++++++++++++++
 tb/tb_cluster_count_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_count_pkg.sv
// Shared types, default widths and helpers for the cluster count sequencer.
package cluster_count_pkg;
  localparam int CNT_W_DEF       = 11;
  localparam int CNT_LATENCY_DEF = 10;
  localparam int BX_PERIOD_DEF   = 4;
  localparam int SAT_W           = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  // Add two values and clamp the result at lim; operands are zero-extended by the caller.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[SAT_W-1:0];
  endfunction
endpackage

// File: rtl/cluster_count_sequencer_delay.sv
// Strobe delay line that follows each BX through the counter pipeline (STAGES >= 2).
module bx_strobe_delay #(
  parameter int STAGES = 10
) (
  input  logic clock4x,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clock4x)
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-2:0], din};

  assign dout = vld_pipe[STAGES-1];
endmodule

// File: rtl/cluster_count_sequencer.sv
// Tags counter outputs with their BX, flags overflow, checks strobe spacing
// and runs commanded occupancy windows with a valid/ack result.
module cluster_count_sequencer
  import cluster_count_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int CNT_LATENCY = CNT_LATENCY_DEF,
  parameter int BX_PERIOD   = BX_PERIOD_DEF,
  parameter int WIN_W       = 16,
  parameter int SUM_W       = 32
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic             bx_strobe_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cont_i,
  input  logic [WIN_W-1:0] window_len_i,
  input  logic             phase_clr_i,
  output logic [CNT_W-1:0] bx_cnt_o,
  output logic             bx_valid_o,
  output logic             bx_overflow_o,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] max_o,
  output logic [WIN_W-1:0] ovf_bx_o,
  output logic             result_valid_o,
  input  logic             result_ack_i,
  output logic             busy_o,
  output logic             phase_err_o
);
  localparam int SPC_W = 8;

  logic             cap;
  logic [SPC_W-1:0] spc_q;
  logic             seen_q;
  state_e           state_q, state_d;
  logic             load, clr_acc, acc_en, last;
  logic [WIN_W-1:0] win_len_q, bx_ctr_q, ovf_q;
  logic [WIN_W:0]   ctr_nxt;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] max_q;

  bx_strobe_delay #(.STAGES(CNT_LATENCY)) u_dly (
    .clock4x (clock4x),
    .reset   (reset),
    .din     (bx_strobe_i),
    .dout    (cap)
  );

  // Capture cycle: count and threshold are sampled together, flags come out a cycle later.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      bx_cnt_o      <= '0;
      bx_valid_o    <= 1'b0;
      bx_overflow_o <= 1'b0;
    end else begin
      bx_valid_o    <= cap;
      bx_overflow_o <= cap && (cnt_i > thresh_i);
      if (cap) bx_cnt_o <= cnt_i;
    end
  end

  // Spacing check; the first strobe after reset or clear only sets the reference.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      spc_q       <= '0;
      seen_q      <= 1'b0;
      phase_err_o <= 1'b0;
    end else begin
      if (bx_strobe_i)      spc_q <= SPC_W'(1);
      else if (spc_q != '1) spc_q <= spc_q + SPC_W'(1);
      if (phase_clr_i) begin
        phase_err_o <= 1'b0;
        seen_q      <= 1'b0;
      end else if (bx_strobe_i) begin
        seen_q <= 1'b1;
        if (seen_q && spc_q != SPC_W'(BX_PERIOD)) phase_err_o <= 1'b1;
      end
    end
  end

  assign ctr_nxt = {1'b0, bx_ctr_q} + (WIN_W+1)'(1);
  assign last    = ctr_nxt >= {1'b0, win_len_q};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr_acc = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE:  if (start_i) begin
               state_d = ACCUM;
               load    = 1'b1;
               clr_acc = 1'b1;
             end
      ACCUM: if (bx_valid_o) begin
               acc_en = 1'b1;
               if (last) state_d = HOLD;
             end
      HOLD:  if (result_ack_i) begin
               state_d = cont_i ? ACCUM : IDLE;
               clr_acc = cont_i;
             end
      default: state_d = IDLE;
    endcase
    // Abort beats everything, including a start in the same cycle.
    if (stop_i) begin
      state_d = IDLE;
      load    = 1'b0;
      clr_acc = 1'b0;
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q   <= IDLE;
      win_len_q <= '0;
      bx_ctr_q  <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      ovf_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) win_len_q <= (window_len_i == '0) ? WIN_W'(1) : window_len_i;
      if (clr_acc) begin
        bx_ctr_q <= '0;
        sum_q    <= '0;
        max_q    <= '0;
        ovf_q    <= '0;
      end else if (acc_en) begin
        bx_ctr_q <= ctr_nxt[WIN_W-1:0];
        sum_q    <= SUM_W'(sat_add(SAT_W'(sum_q), SAT_W'(bx_cnt_o), SAT_W'({SUM_W{1'b1}})));
        ovf_q    <= WIN_W'(sat_add(SAT_W'(ovf_q), SAT_W'(bx_overflow_o), SAT_W'({WIN_W{1'b1}})));
        if (bx_cnt_o > max_q) max_q <= bx_cnt_o;
      end
    end
  end

  assign sum_o          = sum_q;
  assign max_o          = max_q;
  assign ovf_bx_o       = ovf_q;
  assign result_valid_o = (state_q == HOLD);
  assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_cluster_count_sequencer.sv
// Directed bench for cluster_count_sequencer; sum width narrowed so saturation is reachable quickly.
module tb_cluster_count_sequencer;
  localparam int CNT_W = 11;
  localparam int WIN_W = 16;
  localparam int SUM_W = 16;

  logic             clock4x, reset, bx_strobe_i, start_i, stop_i, cont_i, phase_clr_i, result_ack_i;
  logic [CNT_W-1:0] cnt_i, thresh_i, bx_cnt_o, max_o;
  logic [WIN_W-1:0] window_len_i, ovf_bx_o;
  logic [SUM_W-1:0] sum_o;
  logic             bx_valid_o, bx_overflow_o, result_valid_o, busy_o, phase_err_o;

  int total = 0;
  int bad   = 0;
  int gen_cyc, gen_n, cur;
  int gen_vals[64];

  cluster_count_sequencer #(.SUM_W(SUM_W)) dut (
    .clock4x(clock4x), .reset(reset), .bx_strobe_i(bx_strobe_i), .cnt_i(cnt_i),
    .thresh_i(thresh_i), .start_i(start_i), .stop_i(stop_i), .cont_i(cont_i),
    .window_len_i(window_len_i), .phase_clr_i(phase_clr_i), .bx_cnt_o(bx_cnt_o),
    .bx_valid_o(bx_valid_o), .bx_overflow_o(bx_overflow_o), .sum_o(sum_o), .max_o(max_o),
    .ovf_bx_o(ovf_bx_o), .result_valid_o(result_valid_o), .result_ack_i(result_ack_i),
    .busy_o(busy_o), .phase_err_o(phase_err_o)
  );

  initial clock4x = 1'b0;
  always #5 clock4x = ~clock4x;

  // One cycle: pulses default low, strobe every 4 cycles, count presented on the capture cycle.
  task automatic step();
    @(negedge clock4x);
    cur          = gen_cyc;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    result_ack_i = 1'b0;
    phase_clr_i  = 1'b0;
    bx_strobe_i  = (cur % 4 == 0) && (cur / 4 < gen_n);
    cnt_i        = '0;
    if (cur >= 10 && (cur - 10) % 4 == 0 && (cur - 10) / 4 < gen_n)
      cnt_i = CNT_W'(gen_vals[(cur - 10) / 4]);
    gen_cyc++;
  endtask

  task automatic gen_start(input int n);
    gen_cyc     = 0;
    gen_n       = n;
    phase_clr_i = 1'b1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if ({bx_valid_o, bx_overflow_o, result_valid_o, busy_o, phase_err_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {bx_valid_o, bx_overflow_o, result_valid_o, busy_o, phase_err_o}); end
    total++; if (bx_cnt_o !== 0 || sum_o !== 0 || max_o !== 0 || ovf_bx_o !== 0) begin
      bad++; $display("FAIL reset_data got cnt=%0d sum=%0d max=%0d ovf=%0d exp all 0", bx_cnt_o, sum_o, max_o, ovf_bx_o); end
    reset = 1'b0;
  endtask

  task automatic test_bx_tag(input int v, input int thr);
    logic exp_v;
    thresh_i = CNT_W'(thr);
    for (int k = 0; k < 64; k++) gen_vals[k] = v;
    gen_start(3);
    for (int c = 0; c < 25; c++) begin
      step();
      exp_v = (c >= 11) && ((c - 11) % 4 == 0) && ((c - 11) / 4 < 3);
      total++; if ({bx_valid_o, bx_overflow_o} !== {exp_v, exp_v && (v > thr)}) begin
        bad++; $display("FAIL bx_flags c=%0d got=%b exp=%b", c, {bx_valid_o, bx_overflow_o}, {exp_v, exp_v && (v > thr)}); end
      if (exp_v) begin
        total++; if (bx_cnt_o !== CNT_W'(v)) begin
          bad++; $display("FAIL bx_cnt c=%0d got=%0d exp=%0d", c, bx_cnt_o, v); end
      end
    end
    total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL bx_phase got=%b exp=0", phase_err_o); end
  endtask

  task automatic test_window();
    thresh_i = 8; window_len_i = 4; cont_i = 0;
    gen_vals[0] = 3; gen_vals[1] = 12; gen_vals[2] = 7; gen_vals[3] = 0;
    start_i = 1'b1;
    gen_start(4);
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 0) begin total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL win_busy got=%b exp=1", busy_o); end end
      if (c == 23) begin total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL win_early got=%b exp=0", result_valid_o); end end
      if (c == 24) begin
        total++; if ({result_valid_o, sum_o, max_o, ovf_bx_o} !== {1'b1, 16'd22, 11'd12, 16'd1}) begin
          bad++; $display("FAIL win_result got rv=%b sum=%0d max=%0d ovf=%0d exp rv=1 sum=22 max=12 ovf=1", result_valid_o, sum_o, max_o, ovf_bx_o); end
      end
      if (c == 30) begin
        total++; if (result_valid_o !== 1'b1 || sum_o !== 22) begin
          bad++; $display("FAIL win_hold got rv=%b sum=%0d exp rv=1 sum=22", result_valid_o, sum_o); end
        result_ack_i = 1'b1;
      end
      if (c == 31) begin
        total++; if ({result_valid_o, busy_o} !== 2'b00 || sum_o !== 22) begin
          bad++; $display("FAIL win_ack got rv=%b busy=%b sum=%0d exp rv=0 busy=0 sum=22", result_valid_o, busy_o, sum_o); end
      end
    end
  endtask

  task automatic test_cont();
    thresh_i = 8; window_len_i = 0; cont_i = 1;
    gen_vals[0] = 4; gen_vals[1] = 9; gen_vals[2] = 6; gen_vals[3] = 10;
    start_i = 1'b1;
    gen_start(4);
    for (int c = 0; c < 28; c++) begin
      step();
      if (c == 11) begin total++; if (result_valid_o !== 1'b0) begin bad++; $display("FAIL cont_early got=%b exp=0", result_valid_o); end end
      if (c == 12) begin
        total++; if ({result_valid_o, sum_o, max_o, ovf_bx_o} !== {1'b1, 16'd4, 11'd4, 16'd0}) begin
          bad++; $display("FAIL cont_first got rv=%b sum=%0d max=%0d ovf=%0d exp rv=1 sum=4 max=4 ovf=0", result_valid_o, sum_o, max_o, ovf_bx_o); end
      end
      if (c == 16 || c == 20) begin
        total++; if (result_valid_o !== 1'b1 || sum_o !== 4 || max_o !== 4) begin
          bad++; $display("FAIL cont_frozen c=%0d got rv=%b sum=%0d max=%0d exp rv=1 sum=4 max=4", c, result_valid_o, sum_o, max_o); end
      end
      if (c == 20) result_ack_i = 1'b1;
      if (c == 21) begin
        total++; if ({result_valid_o, busy_o} !== 2'b01 || sum_o !== 0) begin
          bad++; $display("FAIL cont_rearm got rv=%b busy=%b sum=%0d exp rv=0 busy=1 sum=0", result_valid_o, busy_o, sum_o); end
      end
      if (c == 22) result_ack_i = 1'b1;
      if (c == 23) begin
        total++; if ({result_valid_o, busy_o} !== 2'b01) begin
          bad++; $display("FAIL cont_stray_ack got rv=%b busy=%b exp rv=0 busy=1", result_valid_o, busy_o); end
      end
      if (c == 24) begin
        total++; if ({result_valid_o, sum_o, max_o, ovf_bx_o} !== {1'b1, 16'd10, 11'd10, 16'd1}) begin
          bad++; $display("FAIL cont_second got rv=%b sum=%0d max=%0d ovf=%0d exp rv=1 sum=10 max=10 ovf=1", result_valid_o, sum_o, max_o, ovf_bx_o); end
      end
      if (c == 25) result_ack_i = 1'b1;
      if (c == 26) begin
        total++; if ({result_valid_o, busy_o} !== 2'b01) begin
          bad++; $display("FAIL cont_third got rv=%b busy=%b exp rv=0 busy=1", result_valid_o, busy_o); end
        stop_i = 1'b1; cont_i = 1'b0;
      end
      if (c == 27) begin total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL cont_stop got=%b exp=0", busy_o); end end
    end
  endtask

  task automatic test_phase();
    gen_start(0);
    for (int c = 0; c < 42; c++) begin
      step();
      if (c == 0 || c == 4 || c == 8 || c == 13 || c == 22 || c == 25) bx_strobe_i = 1'b1;
      if (c == 12 || c == 13) begin total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL phase_ok c=%0d got=%b exp=0", c, phase_err_o); end end
      if (c == 14 || c == 20) begin total++; if (phase_err_o !== 1'b1) begin bad++; $display("FAIL phase_set c=%0d got=%b exp=1", c, phase_err_o); end end
      if (c == 20 || c == 25) phase_clr_i = 1'b1;
      if (c == 21 || c == 26) begin total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL phase_clr c=%0d got=%b exp=0", c, phase_err_o); end end
    end
  endtask

  task automatic test_reset_mid();
    int nval;
    nval = 0;
    thresh_i = 8; window_len_i = 4; cont_i = 0;
    for (int k = 0; k < 64; k++) gen_vals[k] = 7;
    start_i = 1'b1;
    gen_start(4);
    for (int c = 0; c < 33; c++) begin
      step();
      if (c == 12) begin
        total++; if (sum_o !== 7 || busy_o !== 1'b1) begin
          bad++; $display("FAIL rst_pre got sum=%0d busy=%b exp sum=7 busy=1", sum_o, busy_o); end
      end
      if (c == 13) reset = 1'b1;
      if (c == 15) begin
        total++; if ({bx_valid_o, bx_overflow_o, result_valid_o, busy_o, phase_err_o} !== 5'b0 ||
                     bx_cnt_o !== 0 || sum_o !== 0 || max_o !== 0 || ovf_bx_o !== 0) begin
          bad++; $display("FAIL rst_mid got busy=%b cnt=%0d sum=%0d max=%0d ovf=%0d exp all 0", busy_o, bx_cnt_o, sum_o, max_o, ovf_bx_o); end
        reset = 1'b0;
      end
      if (c >= 15 && bx_valid_o === 1'b1) nval++;
    end
    total++; if (nval !== 0) begin bad++; $display("FAIL rst_dropped got=%0d valids exp=0", nval); end
  endtask

  task automatic test_saturate();
    thresh_i = 2046; window_len_i = 16'hFFFF; cont_i = 0;
    for (int k = 0; k < 64; k++) gen_vals[k] = 2047;
    start_i = 1'b1;
    gen_start(34);
    for (int c = 0; c < 148; c++) begin
      step();
      if (c == 136) begin
        total++; if (sum_o !== 16'd65504 || ovf_bx_o !== 32) begin
          bad++; $display("FAIL sat_below got sum=%0d ovf=%0d exp sum=65504 ovf=32", sum_o, ovf_bx_o); end
      end
      if (c == 140) begin
        total++; if (sum_o !== 16'hFFFF || max_o !== 2047 || ovf_bx_o !== 33) begin
          bad++; $display("FAIL sat_hit got sum=%0h max=%0d ovf=%0d exp sum=ffff max=2047 ovf=33", sum_o, max_o, ovf_bx_o); end
      end
      if (c == 144) begin
        total++; if (sum_o !== 16'hFFFF || ovf_bx_o !== 34) begin
          bad++; $display("FAIL sat_stay got sum=%0h ovf=%0d exp sum=ffff ovf=34", sum_o, ovf_bx_o); end
      end
      if (c == 145 || c == 146) begin start_i = 1'b1; stop_i = 1'b1; end
      if (c == 146 || c == 147) begin
        total++; if ({busy_o, result_valid_o} !== 2'b00 || sum_o !== 16'hFFFF) begin
          bad++; $display("FAIL sat_stop c=%0d got busy=%b rv=%b sum=%0h exp busy=0 rv=0 sum=ffff", c, busy_o, result_valid_o, sum_o); end
      end
    end
    total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL sat_phase got=%b exp=0", phase_err_o); end
  endtask

  initial begin
    reset = 1'b1; bx_strobe_i = 0; cnt_i = '0; thresh_i = '0; start_i = 0; stop_i = 0;
    cont_i = 0; window_len_i = '0; phase_clr_i = 0; result_ack_i = 0;
    gen_cyc = 0; gen_n = 0; cur = 0;
    for (int k = 0; k < 64; k++) gen_vals[k] = 0;
    test_reset();
    test_bx_tag(5, 8);
    test_bx_tag(9, 8);
    test_window();
    test_cont();
    test_phase();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
